// File: rtl/minesweeper_pkg.sv
// Shared minesweeper definitions: placer state encoding, LFSR polynomial and
// coordinate/count width helpers used by mine_placer and Board.
package minesweeper_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_GEN,
      ST_CHECK,
      ST_PLACE,
      ST_DONE
   } placer_state_t;

   // Taps for x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
   localparam logic [15:0] LFSR_MASK = 16'hB400;

   function automatic int coord_width(input int cells);
      return (cells <= 2) ? 1 : $clog2(cells);
   endfunction

   function automatic int count_width(input int max_count);
      return (max_count < 1) ? 1 : $clog2(max_count + 1);
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_MASK : 16'h0000);
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with synchronous load and step enable; load wins over step.
module lfsr16
   import minesweeper_pkg::*;
#(
   parameter logic [15:0] RESET_VALUE = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic [15:0] load_value,
   input  logic        step,
   output logic [15:0] state
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= RESET_VALUE;
      end else if (load) begin
         state <= load_value;
      end else if (step) begin
         state <= lfsr_next(state);
      end
   end

endmodule

// File: rtl/mine_placer.sv
// Fills the mine and adjacency boards with NUM_MINES distinct pseudo-random
// mines, never on the player's first-clicked cell.
module mine_placer
   import minesweeper_pkg::*;
#(
   parameter int          WIDTH     = 8,
   parameter int          HEIGHT    = 8,
   parameter int          NUM_MINES = 10,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   localparam int         XW        = coord_width(WIDTH),
   localparam int         YW        = coord_width(HEIGHT),
   localparam int         CW        = count_width(NUM_MINES)
) (
   input  logic          clk_tb,
   input  logic          reset_tb,
   input  logic          start,
   input  logic [15:0]   seed,
   input  logic [XW-1:0] safeX,
   input  logic [YW-1:0] safeY,
   output logic          busy,
   output logic          done,
   output logic          boardClr,
   output logic [XW-1:0] readX,
   output logic [YW-1:0] readY,
   input  logic          readValue,
   output logic          placeMineEn,
   output logic [XW-1:0] placeMineX,
   output logic [YW-1:0] placeMineY,
   output logic [CW-1:0] minesPlaced
);

   if (WIDTH < 2 || WIDTH > 16 || HEIGHT < 2 || HEIGHT > 16) begin : g_bad_dims
      $error("mine_placer: WIDTH and HEIGHT must lie in 2..16");
   end
   if (NUM_MINES < 1 || NUM_MINES > WIDTH * HEIGHT - 1) begin : g_bad_mines
      $error("mine_placer: NUM_MINES must lie in 1..WIDTH*HEIGHT-1");
   end

   placer_state_t state;
   logic [XW-1:0] cand_x;
   logic [YW-1:0] cand_y;
   logic [XW-1:0] safe_x;
   logic [YW-1:0] safe_y;
   logic [15:0]   lfsr_q;
   logic [15:0]   next_lfsr;
   logic [15:0]   load_value;
   logic          lfsr_load;
   logic          lfsr_step;
   logic          out_of_range;
   logic          hits_safe;
   logic          reject;
   logic [CW-1:0] count_inc;
   logic          unused_lfsr_bits;

   // A zero seed would lock the LFSR, so it falls back to the built-in seed
   assign load_value = (seed == 16'h0000) ? LFSR_SEED : seed;
   assign lfsr_load  = (state == ST_IDLE) && start;
   assign lfsr_step  = (state == ST_GEN);
   assign next_lfsr  = lfsr_next(lfsr_q);

   assign unused_lfsr_bits = ^next_lfsr[15:XW+YW];

   lfsr16 #(
      .RESET_VALUE(LFSR_SEED)
   ) u_lfsr (
      .clk       (clk_tb),
      .reset_n   (reset_tb),
      .load      (lfsr_load),
      .load_value(load_value),
      .step      (lfsr_step),
      .state     (lfsr_q)
   );

   assign out_of_range = ({1'b0, cand_x} >= (XW+1)'(WIDTH)) ||
                         ({1'b0, cand_y} >= (YW+1)'(HEIGHT));
   assign hits_safe    = (cand_x == safe_x) && (cand_y == safe_y);
   assign reject       = out_of_range || hits_safe || readValue;
   assign count_inc    = minesPlaced + 1'b1;

   assign readX      = cand_x;
   assign readY      = cand_y;
   assign placeMineX = cand_x;
   assign placeMineY = cand_y;

   // Outputs are registered alongside the state so they track the state entered
   always_ff @(posedge clk_tb or negedge reset_tb) begin
      if (!reset_tb) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         boardClr    <= 1'b0;
         placeMineEn <= 1'b0;
         minesPlaced <= '0;
         cand_x      <= '0;
         cand_y      <= '0;
         safe_x      <= '0;
         safe_y      <= '0;
      end else begin
         done        <= 1'b0;
         boardClr    <= 1'b0;
         placeMineEn <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  safe_x      <= safeX;
                  safe_y      <= safeY;
                  minesPlaced <= '0;
                  busy        <= 1'b1;
                  boardClr    <= 1'b1;
                  state       <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               state <= ST_GEN;
            end
            ST_GEN: begin
               cand_x <= next_lfsr[XW-1:0];
               cand_y <= next_lfsr[XW+YW-1:XW];
               state  <= ST_CHECK;
            end
            ST_CHECK: begin
               if (reject) begin
                  state <= ST_GEN;
               end else begin
                  placeMineEn <= 1'b1;
                  state       <= ST_PLACE;
               end
            end
            ST_PLACE: begin
               minesPlaced <= count_inc;
               if (count_inc == CW'(NUM_MINES)) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  state <= ST_GEN;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mine_placer.sv
// Scoreboard bench for mine_placer: three configurations share one clock, with
// behavioural mine/adjacency boards feeding readValue.
module tb_mine_placer;

   typedef struct packed {
      logic [2:0] x;
      logic [2:0] y;
   } coord_t;

   logic clk_tb = 1'b0;
   always #5 clk_tb = ~clk_tb;

   logic        rst    [3];
   logic        start  [3];
   logic [15:0] seed   [3];
   logic [2:0]  sfx    [3];
   logic [2:0]  sfy    [3];
   logic        busy_s [3];
   logic        done_s [3];
   logic        clr_s  [3];
   logic        pme_s  [3];
   logic        rv     [3];
   logic [2:0]  rdx    [3];
   logic [2:0]  rdy    [3];
   logic [2:0]  pmx    [3];
   logic [2:0]  pmy    [3];
   logic [3:0]  mp0;
   logic [5:0]  mp1;
   logic [3:0]  mp2;

   logic mine_b [3][8][8];
   int   adj_b  [3][8][8];

   int      checks = 0;
   int      errors = 0;
   int      cyc = 0;
   coord_t  exp_q [$];
   coord_t  log_a [$];
   coord_t  anchor [3];
   int      exp_lat;
   int      exp_oor;
   int      done_cnt  [3];
   int      done_base [3];
   logic    chk_rst   [3];
   logic    tmo_req;
   logic    anchor_en;
   logic    record_mode;
   logic    compare_mode;

   mine_placer #(.WIDTH(8), .HEIGHT(8), .NUM_MINES(10), .LFSR_SEED(16'hACE1)) dut0 (
      .clk_tb(clk_tb), .reset_tb(rst[0]), .start(start[0]), .seed(seed[0]),
      .safeX(sfx[0]), .safeY(sfy[0]), .busy(busy_s[0]), .done(done_s[0]),
      .boardClr(clr_s[0]), .readX(rdx[0]), .readY(rdy[0]), .readValue(rv[0]),
      .placeMineEn(pme_s[0]), .placeMineX(pmx[0]), .placeMineY(pmy[0]),
      .minesPlaced(mp0));

   mine_placer #(.WIDTH(8), .HEIGHT(8), .NUM_MINES(63), .LFSR_SEED(16'hACE1)) dut1 (
      .clk_tb(clk_tb), .reset_tb(rst[1]), .start(start[1]), .seed(seed[1]),
      .safeX(sfx[1]), .safeY(sfy[1]), .busy(busy_s[1]), .done(done_s[1]),
      .boardClr(clr_s[1]), .readX(rdx[1]), .readY(rdy[1]), .readValue(rv[1]),
      .placeMineEn(pme_s[1]), .placeMineX(pmx[1]), .placeMineY(pmy[1]),
      .minesPlaced(mp1));

   mine_placer #(.WIDTH(5), .HEIGHT(6), .NUM_MINES(8), .LFSR_SEED(16'hACE1)) dut2 (
      .clk_tb(clk_tb), .reset_tb(rst[2]), .start(start[2]), .seed(seed[2]),
      .safeX(sfx[2]), .safeY(sfy[2]), .busy(busy_s[2]), .done(done_s[2]),
      .boardClr(clr_s[2]), .readX(rdx[2]), .readY(rdy[2]), .readValue(rv[2]),
      .placeMineEn(pme_s[2]), .placeMineX(pmx[2]), .placeMineY(pmy[2]),
      .minesPlaced(mp2));

   function automatic int wd(input int g);
      return (g == 2) ? 5 : 8;
   endfunction

   function automatic int ht(input int g);
      return (g == 2) ? 6 : 8;
   endfunction

   function automatic int nm(input int g);
      return (g == 0) ? 10 : ((g == 1) ? 63 : 8);
   endfunction

   function automatic int mp_of(input int g);
      return (g == 0) ? int'(mp0) : ((g == 1) ? int'(mp1) : int'(mp2));
   endfunction

   function automatic bit in_board(input int g, input int x, input int y);
      return (x >= 0) && (y >= 0) && (x < wd(g)) && (y < ht(g));
   endfunction

   for (genvar gi = 0; gi < 3; gi++) begin : g_read
      assign rv[gi] = mine_b[gi][rdx[gi]][rdy[gi]];
   end

   always @(posedge clk_tb) cyc <= cyc + 1;

   // Behavioural boards: boardClr clears, placeMineEn sets the mine and bumps neighbours
   always @(posedge clk_tb) begin
      for (int g = 0; g < 3; g++) begin
         if (clr_s[g]) begin
            for (int x = 0; x < 8; x++)
               for (int y = 0; y < 8; y++) begin
                  mine_b[g][x][y] <= 1'b0;
                  adj_b[g][x][y]  <= 0;
               end
         end else if (pme_s[g]) begin
            mine_b[g][pmx[g]][pmy[g]] <= 1'b1;
            for (int dx = -1; dx <= 1; dx++)
               for (int dy = -1; dy <= 1; dy++)
                  if ((dx != 0 || dy != 0) && in_board(g, int'(pmx[g]) + dx, int'(pmy[g]) + dy))
                     adj_b[g][int'(pmx[g]) + dx][int'(pmy[g]) + dy] <=
                        adj_b[g][int'(pmx[g]) + dx][int'(pmy[g]) + dy] + 1;
         end
      end
   end

   // Reference placement sequence built straight from the LFSR and acceptance rules
   function automatic void model_run(input int g, input logic [15:0] sd, input int sx, input int sy);
      bit          brd [8][8];
      logic [15:0] s;
      int          placed = 0;
      int          rej = 0;
      int          oor = 0;
      int          iter = 0;
      int          cx;
      int          cy;
      coord_t      c;
      s = (sd == 16'h0000) ? 16'hACE1 : sd;
      for (int x = 0; x < 8; x++)
         for (int y = 0; y < 8; y++)
            brd[x][y] = 1'b0;
      while (placed < nm(g) && iter < 200000) begin
         iter++;
         s  = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
         cx = int'(s[2:0]);
         cy = int'(s[5:3]);
         if (cx >= wd(g) || cy >= ht(g)) begin
            rej++;
            oor++;
         end else if ((cx == sx && cy == sy) || brd[cx][cy]) begin
            rej++;
         end else begin
            brd[cx][cy] = 1'b1;
            c.x = 3'(cx);
            c.y = 3'(cy);
            exp_q.push_back(c);
            placed++;
         end
      end
      exp_lat = 1 + 3 * placed + 2 * rej;
      exp_oor = oor;
   endfunction

   task automatic checkOutput(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard on each placement and audits every finished run
   initial begin : monitor
      bit      pend   [3];
      int      st_cyc [3];
      int      pidx   [3];
      int      cur_sx [3];
      int      cur_sy [3];
      int      pnd_sx [3];
      int      pnd_sy [3];
      int      oor_obs;
      int      bad;
      int      total;
      int      refc;
      coord_t  e;
      oor_obs = 0;
      for (int g = 0; g < 3; g++) begin
         pend[g] = 1'b0; st_cyc[g] = 0; pidx[g] = 0; done_cnt[g] = 0;
         cur_sx[g] = 0; cur_sy[g] = 0; pnd_sx[g] = 0; pnd_sy[g] = 0;
      end
      forever begin
         @(negedge clk_tb);
         if (tmo_req) checkOutput("done_timeout", 0, 1);
         for (int g = 0; g < 3; g++) begin
            if (chk_rst[g]) begin
               checkOutput("rst_busy", int'(busy_s[g]), 0);
               checkOutput("rst_done", int'(done_s[g]), 0);
               checkOutput("rst_boardClr", int'(clr_s[g]), 0);
               checkOutput("rst_placeMineEn", int'(pme_s[g]), 0);
               checkOutput("rst_minesPlaced", mp_of(g), 0);
               checkOutput("rst_coords", int'({rdx[g], rdy[g], pmx[g], pmy[g]}), 0);
            end
            if (pend[g]) begin
               pend[g] = 1'b0;
               checkOutput("accept_boardClr", int'(clr_s[g]), 1);
               checkOutput("accept_busy", int'(busy_s[g]), 1);
               st_cyc[g] = cyc;
               pidx[g]   = 0;
               cur_sx[g] = pnd_sx[g];
               cur_sy[g] = pnd_sy[g];
               if (g == 2) oor_obs = 0;
            end
            if (pme_s[g]) begin
               if (exp_q.size() == 0) begin
                  checkOutput("pulse_expected", 0, 1);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("pulse_coord", int'(pmx[g]) * 10 + int'(pmy[g]), int'(e.x) * 10 + int'(e.y));
               end
               checkOutput("pulse_in_range", int'(int'(pmx[g]) < wd(g) && int'(pmy[g]) < ht(g)), 1);
               checkOutput("pulse_not_safe", int'(int'(pmx[g]) == cur_sx[g] && int'(pmy[g]) == cur_sy[g]), 0);
               checkOutput("pulse_distinct", int'(mine_b[g][pmx[g]][pmy[g]] === 1'b1), 0);
               if (g == 0 && anchor_en && pidx[g] < 3)
                  checkOutput("pulse_anchor", int'(pmx[g]) * 10 + int'(pmy[g]),
                              int'(anchor[pidx[g]].x) * 10 + int'(anchor[pidx[g]].y));
               if (g == 0 && record_mode) begin
                  e.x = pmx[g];
                  e.y = pmy[g];
                  log_a.push_back(e);
               end
               if (g == 0 && compare_mode)
                  checkOutput("seed0_vs_ace1", int'(pmx[g]) * 10 + int'(pmy[g]),
                              (pidx[g] < log_a.size()) ? int'(log_a[pidx[g]].x) * 10 + int'(log_a[pidx[g]].y) : -1);
               pidx[g]++;
            end
            if (g == 2 && busy_s[2] && (rdx[2] >= 3'd5 || rdy[2] >= 3'd6)) oor_obs++;
            if (done_s[g]) begin
               checkOutput("done_latency", cyc - st_cyc[g], exp_lat);
               checkOutput("mines_placed", mp_of(g), nm(g));
               checkOutput("pulse_count", pidx[g], nm(g));
               checkOutput("queue_drained", exp_q.size(), 0);
               bad   = 0;
               total = 0;
               for (int x = 0; x < wd(g); x++)
                  for (int y = 0; y < ht(g); y++) begin
                     refc = 0;
                     for (int dx = -1; dx <= 1; dx++)
                        for (int dy = -1; dy <= 1; dy++)
                           if ((dx != 0 || dy != 0) && in_board(g, x + dx, y + dy))
                              if (mine_b[g][x + dx][y + dy] === 1'b1) refc++;
                     if (refc != adj_b[g][x][y]) bad++;
                     if (mine_b[g][x][y] === 1'b1) total++;
                  end
               checkOutput("adjacency_cells", bad, 0);
               checkOutput("mine_total", total, nm(g));
               if (g == 1) checkOutput("safe_corner_empty", int'(mine_b[1][0][0] === 1'b1), 0);
               if (g == 2) begin
                  checkOutput("oor_observed", oor_obs, 2 * exp_oor);
                  checkOutput("oor_seen", int'(oor_obs > 0), 1);
               end
               done_cnt[g]++;
            end
            if (rst[g] && start[g] && !busy_s[g]) begin
               pend[g]   = 1'b1;
               pnd_sx[g] = int'(sfx[g]);
               pnd_sy[g] = int'(sfy[g]);
            end
         end
      end
   end

   task automatic applyStimulus(input int g, input logic [15:0] sd, input logic [2:0] sx, input logic [2:0] sy);
      @(posedge clk_tb);
      #2;
      done_base[g] = done_cnt[g];
      seed[g]  = sd;
      sfx[g]   = sx;
      sfy[g]   = sy;
      start[g] = 1'b1;
      @(posedge clk_tb);
      #2;
      start[g] = 1'b0;
   endtask

   task automatic waitDone(input int g, input int bound);
      int n = 0;
      while (done_cnt[g] == done_base[g] && n < bound) begin
         @(posedge clk_tb);
         n++;
      end
      if (done_cnt[g] == done_base[g]) begin
         tmo_req = 1'b1;
         @(negedge clk_tb);
         #1;
         tmo_req = 1'b0;
      end
      repeat (2) @(posedge clk_tb);
   endtask

   initial begin : stimulus
      int n;
      anchor[0] = {3'd0, 3'd6};
      anchor[1] = {3'd0, 3'd7};
      anchor[2] = {3'd4, 3'd3};
      for (int g = 0; g < 3; g++) begin
         rst[g] = 1'b0; start[g] = 1'b0; seed[g] = 16'h0000;
         sfx[g] = 3'd0; sfy[g] = 3'd0; chk_rst[g] = 1'b1; done_base[g] = 0;
      end
      tmo_req = 1'b0; anchor_en = 1'b0; record_mode = 1'b0; compare_mode = 1'b0;
      repeat (3) @(posedge clk_tb);
      #2;
      for (int g = 0; g < 3; g++) begin
         chk_rst[g] = 1'b0;
         rst[g]     = 1'b1;
      end

      $display("[TB] 8x8 / 10 mines, seed ACE1, safe (3,3)");
      anchor_en   = 1'b1;
      record_mode = 1'b1;
      model_run(0, 16'hACE1, 3, 3);
      applyStimulus(0, 16'hACE1, 3'd3, 3'd3);
      waitDone(0, 3000);
      record_mode = 1'b0;

      $display("[TB] seed 0 replay with an ignored start while busy");
      compare_mode = 1'b1;
      model_run(0, 16'h0000, 3, 3);
      applyStimulus(0, 16'h0000, 3'd3, 3'd3);
      repeat (6) @(posedge clk_tb);
      #2;
      seed[0] = 16'h1234; sfx[0] = 3'd1; sfy[0] = 3'd1; start[0] = 1'b1;
      @(posedge clk_tb);
      #2;
      start[0] = 1'b0;
      waitDone(0, 3000);
      compare_mode = 1'b0;
      anchor_en    = 1'b0;

      $display("[TB] 8x8 / 63 mines, safe (0,0)");
      model_run(1, 16'hACE1, 0, 0);
      applyStimulus(1, 16'hACE1, 3'd0, 3'd0);
      waitDone(1, 40000);

      $display("[TB] 5x6 / 8 mines, safe (2,2)");
      model_run(2, 16'hACE1, 2, 2);
      applyStimulus(2, 16'hACE1, 3'd2, 3'd2);
      waitDone(2, 5000);

      $display("[TB] reset during the 4th placement, then a full run");
      model_run(0, 16'hACE1, 3, 3);
      applyStimulus(0, 16'hACE1, 3'd3, 3'd3);
      n = 0;
      for (int i = 0; i < 2000 && n < 4; i++) begin
         @(posedge clk_tb);
         #1;
         if (pme_s[0]) n++;
      end
      rst[0]     = 1'b0;
      chk_rst[0] = 1'b1;
      @(negedge clk_tb);
      #1;
      chk_rst[0] = 1'b0;
      exp_q.delete();
      @(posedge clk_tb);
      #2;
      rst[0] = 1'b1;
      model_run(0, 16'hACE1, 3, 3);
      applyStimulus(0, 16'hACE1, 3'd3, 3'd3);
      waitDone(0, 3000);

      repeat (3) @(negedge clk_tb);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
